// File: rtl/cpu_multicycle_if.sv
// Instruction and data memory ports of the multicycle core, each a req/ack handshake.
// The core drives through the master modport; the RAM side uses slave.
interface cpu_multicycle_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              I_REQ;
  logic [ADDR_W-1:0] I_ADDR;
  logic              I_ACK;
  logic [15:0]       I_DATA;
  logic              D_REQ;
  logic              D_WE;
  logic [ADDR_W-1:0] D_ADDR;
  logic [DATA_W-1:0] D_WDATA;
  logic              D_ACK;
  logic [DATA_W-1:0] D_RDATA;

  modport master (
    output I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA,
    input  I_ACK, I_DATA, D_ACK, D_RDATA
  );

  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA,
    output I_ACK, I_DATA, D_ACK, D_RDATA
  );
endinterface

// File: rtl/cpu_multicycle.sv
// Multicycle 16-bit-ISA core: FETCH/DECODE/EXEC/MEM/WB state machine with 8 x DATA_W registers.
// Every memory access waits for its ack, so wait-stated RAMs simply stretch FETCH or MEM.
module cpu_multicycle #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN_L,
  cpu_multicycle_if.master  bus,
  output logic [ADDR_W-1:0] PC,
  output logic              HALTED,
  output logic              RETIRE,
  output logic              ILLEGAL
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_BZ   = 4'h5;
  localparam logic [3:0] OP_BNZ  = 4'h6;
  localparam logic [3:0] OP_BN   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t            state, state_nxt;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] a_r, b_r, alu_r, mdr;
  logic [ADDR_W-1:0] d_addr_r;
  logic [DATA_W-1:0] d_wdata_r;
  logic              en_l_q, retire_r;

  logic [3:0]        op;
  logic [2:0]        dr, sa, sb, fs;
  logic [DATA_W-1:0] imm_ext, alu_b, alu_y;
  logic [2:0]        alu_fs;
  logic [ADDR_W-1:0] off_ext, pc_seq, pc_br;
  logic              br_taken, illegal_op, resume;

  assign op = ir[15:12];
  assign dr = ir[11:9];
  assign sa = ir[8:6];
  assign sb = ir[5:3];
  assign fs = ir[2:0];

  assign imm_ext    = DATA_W'({{DATA_W{ir[5]}}, ir[5:0]});
  assign off_ext    = ADDR_W'({{ADDR_W{ir[5]}}, ir[5:0]});
  assign pc_seq     = PC + ADDR_W'(2);
  assign pc_br      = pc_seq + (off_ext << 1);
  assign illegal_op = op[3] && (op != OP_HALT);
  assign resume     = (state == S_HALT) && en_l_q && !EN_L;

  // Non-ALU opcodes reuse the adder for ADDI and address calculation.
  assign alu_b  = (op == OP_ALU) ? b_r : imm_ext;
  assign alu_fs = (op == OP_ALU) ? fs  : 3'd0;

  always_comb begin
    alu_y = '0;
    case (alu_fs)
      3'd0: alu_y = a_r + alu_b;
      3'd1: alu_y = a_r - alu_b;
      3'd2: alu_y = a_r & alu_b;
      3'd3: alu_y = a_r | alu_b;
      3'd4: alu_y = a_r ^ alu_b;
      3'd5: alu_y = a_r << 1;
      3'd6: alu_y = a_r >> 1;
      default: alu_y = a_r;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (op)
      OP_BZ:   br_taken = (a_r == '0);
      OP_BNZ:  br_taken = (a_r != '0);
      OP_BN:   br_taken = a_r[DATA_W-1];
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (bus.I_ACK) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_LD, OP_ST:    state_nxt = S_MEM;
          OP_ALU, OP_ADDI: state_nxt = S_WB;
          OP_HALT:         state_nxt = S_HALT;
          default:         state_nxt = S_FETCH;
        endcase
      end
      S_MEM:    if (bus.D_ACK) state_nxt = (op == OP_LD) ? S_WB : S_FETCH;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   if (resume) state_nxt = S_FETCH;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // The state register parks in FETCH during reset, so I_REQ alone needs the reset gate.
  always_comb begin
    bus.I_REQ   = (state == S_FETCH) && !RESET;
    bus.I_ADDR  = PC;
    bus.D_REQ   = (state == S_MEM);
    bus.D_WE    = (state == S_MEM) && (op == OP_ST);
    bus.D_ADDR  = d_addr_r;
    bus.D_WDATA = d_wdata_r;
    HALTED      = (state == S_HALT);
    ILLEGAL     = (state == S_EXEC) && illegal_op;
    RETIRE      = retire_r;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PC        <= '0;
      ir        <= '0;
      a_r       <= '0;
      b_r       <= '0;
      alu_r     <= '0;
      mdr       <= '0;
      d_addr_r  <= '0;
      d_wdata_r <= '0;
      en_l_q    <= 1'b1;
      retire_r  <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      en_l_q   <= EN_L;
      // Resuming from HALT is not a completion: HALT already retired on entry.
      retire_r <= ((state_nxt == S_FETCH) && (state != S_FETCH) && (state != S_HALT)) ||
                  ((state_nxt == S_HALT) && (state != S_HALT));
      case (state)
        S_FETCH: if (bus.I_ACK) ir <= bus.I_DATA;
        S_DECODE: begin
          a_r <= regs[sa];
          b_r <= (op == OP_ST) ? regs[dr] : regs[sb];
        end
        S_EXEC: begin
          alu_r     <= alu_y;
          d_addr_r  <= ADDR_W'(alu_y);
          d_wdata_r <= b_r;
          if (state_nxt == S_FETCH) PC <= br_taken ? pc_br : pc_seq;
        end
        S_MEM: begin
          if (bus.D_ACK) begin
            mdr <= bus.D_RDATA;
            if (op == OP_ST) PC <= pc_seq;
          end
        end
        S_WB: begin
          if (dr != 3'd0) regs[dr] <= (op == OP_LD) ? mdr : alu_r;
          PC <= pc_seq;
        end
        S_HALT: if (resume) PC <= pc_seq;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: wait-state RAM model, ALU vector table, multicycle sequences.
module tb_cpu_multicycle;
  logic       CLK;
  logic       RESET;
  logic       EN_L;
  logic [7:0] PC;
  logic       HALTED, RETIRE, ILLEGAL;

  cpu_multicycle_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  cpu_multicycle #(.DATA_W(8), .ADDR_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .EN_L(EN_L), .bus(bus),
    .PC(PC), .HALTED(HALTED), .RETIRE(RETIRE), .ILLEGAL(ILLEGAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [15:0] imem [256];
  logic [7:0]  dmem [256];
  int i_wait, d_wait, i_cnt, d_len, cyc, ill_cnt;
  int ret_cyc[$], ret_pc[$];
  int acc_we[$], acc_addr[$], acc_data[$], acc_len[$], acc_stab[$];
  logic [7:0] d_a0, d_w0;
  logic       d_we0, d_stab;
  int checks, errors, rb, ab, ib;

  // RAM model and event logger, all on the falling edge.
  always @(negedge CLK) begin
    cyc++;
    if (RETIRE) begin ret_cyc.push_back(cyc); ret_pc.push_back(int'(PC)); end
    if (ILLEGAL) ill_cnt++;
    if (bus.I_REQ) begin
      if (i_cnt >= i_wait) begin
        bus.I_ACK = 1'b1; bus.I_DATA = imem[bus.I_ADDR]; i_cnt = 0;
      end else begin
        bus.I_ACK = 1'b0; i_cnt++;
      end
    end else begin
      bus.I_ACK = 1'b0; i_cnt = 0;
    end
    if (bus.D_REQ) begin
      if (d_len == 0) begin
        d_a0 = bus.D_ADDR; d_w0 = bus.D_WDATA; d_we0 = bus.D_WE; d_stab = 1'b1;
      end else if (bus.D_ADDR !== d_a0 || bus.D_WDATA !== d_w0 || bus.D_WE !== d_we0) begin
        d_stab = 1'b0;
      end
      d_len++;
      if (d_len > d_wait) begin
        bus.D_ACK = 1'b1;
        if (bus.D_WE) dmem[bus.D_ADDR] = bus.D_WDATA;
        else          bus.D_RDATA = dmem[bus.D_ADDR];
        acc_we.push_back(int'(bus.D_WE));
        acc_addr.push_back(int'(bus.D_ADDR));
        acc_data.push_back(bus.D_WE ? int'(bus.D_WDATA) : int'(dmem[bus.D_ADDR]));
        acc_len.push_back(d_len);
        acc_stab.push_back(int'(d_stab));
        d_len = 0;
      end else begin
        bus.D_ACK = 1'b0;
      end
    end else begin
      bus.D_ACK = 1'b0; d_len = 0;
    end
  end

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] d, a, b, f);
    return {op, d, a, b, f};
  endfunction

  function automatic logic [15:0] ri(input logic [3:0] op, input logic [2:0] d, a, input int imm);
    return {op, d, a, imm[5:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK); #1;
  endtask

  task automatic clr_prog();
    RESET = 1'b1; EN_L = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  task automatic release_run(input int iw, input int dw);
    i_wait = iw; d_wait = dw;
    rb = ret_cyc.size(); ab = acc_we.size(); ib = ill_cnt;
    @(posedge CLK); #1 RESET = 1'b0;
    tick();
    chk("first fetch I_REQ", bus.I_REQ, 1);
    chk("first fetch I_ADDR", bus.I_ADDR, 0);
  endtask

  task automatic wait_halt(input string name, input int budget);
    int n;
    n = 0;
    while (HALTED !== 1'b1 && n < budget) begin tick(); n++; end
    chk({name, " reaches HALT"}, HALTED, 1);
  endtask

  task automatic wait_ret(input string name, input int cnt, input int budget);
    int n;
    n = 0;
    while (ret_cyc.size() < rb + cnt && n < budget) begin tick(); n++; end
    chk({name, " retire count"}, ret_cyc.size() >= rb + cnt, 1);
  endtask

  typedef struct {
    string      name;
    logic [2:0] fs;
    int         a;
    int         b;
    logic [7:0] exp;
  } alu_vec_t;

  alu_vec_t vt[10];

  initial begin
    int bad;
    checks = 0; errors = 0;
    vt[0] = '{"alu add",      3'd0,   5,  -3, 8'h02};
    vt[1] = '{"alu sub neg",  3'd1,   5,   7, 8'hFE};
    vt[2] = '{"alu and",      3'd2,  31,  -4, 8'h1C};
    vt[3] = '{"alu or",       3'd3,  18,   5, 8'h17};
    vt[4] = '{"alu xor",      3'd4,  -1,  15, 8'hF0};
    vt[5] = '{"alu shl1",     3'd5, -32,   0, 8'hC0};
    vt[6] = '{"alu shr1",     3'd6,  -2,   0, 8'h7F};
    vt[7] = '{"alu pass",     3'd7,  -7,   0, 8'hF9};
    vt[8] = '{"alu add wrap", 3'd0, -32, -32, 8'hC0};
    vt[9] = '{"alu sub 0-1",  3'd1,   0,   1, 8'hFF};

    RESET = 1'b0; EN_L = 1'b1; i_wait = 0; d_wait = 0;
    #1 RESET = 1'b1;
    tick(); tick();
    chk("reset I_REQ", bus.I_REQ, 0);
    chk("reset D_REQ", bus.D_REQ, 0);
    chk("reset D_WE", bus.D_WE, 0);
    chk("reset RETIRE", RETIRE, 0);
    chk("reset ILLEGAL", ILLEGAL, 0);
    chk("reset HALTED", HALTED, 0);
    chk("reset PC", PC, 0);
    chk("reset D_ADDR", bus.D_ADDR, 0);
    chk("reset D_WDATA", bus.D_WDATA, 0);

    // ALU table: R1=a, R2=b, R3=R1 fs R2, store R3 to [0].
    for (int v = 0; v < 10; v++) begin
      clr_prog();
      imem[0] = ri(4'h2, 3'd1, 3'd0, vt[v].a);
      imem[2] = ri(4'h2, 3'd2, 3'd0, vt[v].b);
      imem[4] = rr(4'h1, 3'd3, 3'd1, 3'd2, vt[v].fs);
      imem[6] = ri(4'h4, 3'd3, 3'd0, 0);
      imem[8] = 16'hF000;
      release_run(0, 0);
      wait_halt(vt[v].name, 100);
      chk(vt[v].name, qget(acc_data, ab), {24'h0, vt[v].exp});
    end

    // Zero-wait ADDI/ADDI/ADD timing.
    clr_prog();
    imem[0] = ri(4'h2, 3'd1, 3'd0, 5);
    imem[2] = ri(4'h2, 3'd2, 3'd0, -3);
    imem[4] = rr(4'h1, 3'd3, 3'd1, 3'd2, 3'd0);
    imem[6] = ri(4'h4, 3'd3, 3'd0, 8);
    imem[8] = 16'hF000;
    release_run(0, 0);
    wait_halt("seq", 100);
    chk("seq addi interval", qget(ret_cyc, rb+1) - qget(ret_cyc, rb), 4);
    chk("seq alu interval", qget(ret_cyc, rb+2) - qget(ret_cyc, rb+1), 4);
    chk("seq PC after 3rd", qget(ret_pc, rb+2), 6);
    chk("seq st interval", qget(ret_cyc, rb+3) - qget(ret_cyc, rb+2), 4);
    chk("seq halt interval", qget(ret_cyc, rb+4) - qget(ret_cyc, rb+3), 3);
    chk("seq R3 stored addr", qget(acc_addr, ab), 8);
    chk("seq R3 value", qget(acc_data, ab), 2);

    // Wait-stated store then load back.
    clr_prog();
    imem[0] = ri(4'h2, 3'd1, 3'd0, 5);
    imem[2] = ri(4'h4, 3'd1, 3'd0, 4);
    imem[4] = ri(4'h3, 3'd4, 3'd0, 4);
    imem[6] = ri(4'h4, 3'd4, 3'd0, 9);
    imem[8] = 16'hF000;
    release_run(1, 3);
    wait_halt("wait st/ld", 200);
    chk("st is store", qget(acc_we, ab), 1);
    chk("st D_REQ cycles", qget(acc_len, ab), 4);
    chk("st addr", qget(acc_addr, ab), 4);
    chk("st data", qget(acc_data, ab), 5);
    chk("st held stable", qget(acc_stab, ab), 1);
    chk("ld is load", qget(acc_we, ab+1), 0);
    chk("ld R4 stored", qget(acc_data, ab+2), 5);
    chk("st interval waits", qget(ret_cyc, rb+1) - qget(ret_cyc, rb), 8);
    chk("ld interval waits", qget(ret_cyc, rb+2) - qget(ret_cyc, rb+1), 9);

    // Branches: forward, backward, not taken.
    clr_prog();
    imem[8'h00] = ri(4'h5, 3'd0, 3'd0, 7);
    imem[8'h10] = ri(4'h5, 3'd0, 3'd0, -2);
    imem[8'h0E] = ri(4'h6, 3'd0, 3'd0, 5);
    release_run(0, 0);
    wait_ret("branch", 3, 50);
    chk("bz fwd PC", qget(ret_pc, rb), 8'h10);
    chk("bz back PC", qget(ret_pc, rb+1), 8'h0E);
    chk("bnz not taken PC", qget(ret_pc, rb+2), 8'h10);
    chk("branch interval", qget(ret_cyc, rb+1) - qget(ret_cyc, rb), 3);

    // BN taken to 0xFE, then PC wraps to 0x00.
    clr_prog();
    imem[8'h00] = ri(4'h2, 3'd1, 3'd0, -1);
    imem[8'h02] = ri(4'h7, 3'd0, 3'd1, -3);
    release_run(0, 0);
    wait_ret("wrap", 3, 50);
    chk("bn taken PC", qget(ret_pc, rb+1), 8'hFE);
    chk("pc wrap", qget(ret_pc, rb+2), 8'h00);

    // BN not taken, then BNZ OFF=-1 spins on itself.
    clr_prog();
    imem[8'h00] = ri(4'h2, 3'd1, 3'd0, 1);
    imem[8'h02] = ri(4'h7, 3'd0, 3'd1, 4);
    imem[8'h04] = ri(4'h6, 3'd0, 3'd1, -1);
    release_run(0, 0);
    wait_ret("spin", 4, 50);
    chk("bn not taken PC", qget(ret_pc, rb+1), 8'h04);
    chk("spin PC", qget(ret_pc, rb+3), 8'h04);

    // HALT at 0x20 and EN_L resume.
    clr_prog();
    imem[8'h00] = ri(4'h5, 3'd0, 3'd0, 15);
    imem[8'h20] = 16'hF000;
    imem[8'h22] = ri(4'h2, 3'd5, 3'd0, 9);
    imem[8'h24] = ri(4'h4, 3'd5, 3'd0, 1);
    imem[8'h26] = 16'hF000;
    release_run(0, 0);
    wait_halt("halt", 50);
    chk("halt retire PC", qget(ret_pc, ret_pc.size()-1), 8'h20);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (HALTED !== 1'b1 || PC !== 8'h20 || bus.I_REQ !== 1'b0) bad++;
    end
    chk("halt hold 50 cycles", bad, 0);
    EN_L = 1'b0;
    tick();
    chk("resume HALTED", HALTED, 0);
    chk("resume I_REQ", bus.I_REQ, 1);
    chk("resume I_ADDR", bus.I_ADDR, 8'h22);
    wait_halt("second halt", 50);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (HALTED !== 1'b1 || PC !== 8'h26) bad++;
    end
    chk("EN_L low no retrigger", bad, 0);
    chk("after resume store", qget(acc_data, ab), 9);
    EN_L = 1'b1;

    // Reset in the middle of a wait-stated store.
    clr_prog();
    imem[0] = ri(4'h2, 3'd1, 3'd0, 3);
    imem[2] = ri(4'h4, 3'd1, 3'd0, 2);
    release_run(0, 10);
    bad = 0;
    while (bus.D_REQ !== 1'b1 && bad < 50) begin tick(); bad++; end
    tick(); tick();
    chk("mid-MEM D_REQ before reset", bus.D_REQ, 1);
    #1 RESET = 1'b1;
    #1;
    chk("async reset D_REQ", bus.D_REQ, 0);
    chk("async reset D_WE", bus.D_WE, 0);
    chk("async reset D_ADDR", bus.D_ADDR, 0);
    chk("async reset I_REQ", bus.I_REQ, 0);
    clr_prog();
    for (int k = 1; k < 8; k++) imem[2*(k-1)] = ri(4'h4, k[2:0], 3'd0, 16 + k);
    imem[14] = 16'hF000;
    release_run(0, 0);
    wait_halt("reg dump", 100);
    chk("reg dump store count", acc_we.size() - ab, 7);
    for (int k = 1; k < 8; k++)
      chk($sformatf("R%0d after reset", k), qget(acc_data, ab + k - 1), 0);

    // Undefined opcode, then a write aimed at R0.
    clr_prog();
    imem[0]  = ri(4'h2, 3'd1, 3'd0, 7);
    imem[2]  = 16'h9249;
    imem[4]  = ri(4'h4, 3'd1, 3'd0, 3);
    imem[6]  = ri(4'h2, 3'd0, 3'd0, 5);
    imem[8]  = ri(4'h4, 3'd0, 3'd0, 4);
    imem[10] = 16'hF000;
    release_run(0, 0);
    wait_halt("illegal", 100);
    chk("illegal pulse cycles", ill_cnt - ib, 1);
    chk("illegal PC+2", qget(ret_pc, rb+1), 4);
    chk("illegal interval", qget(ret_cyc, rb+1) - qget(ret_cyc, rb), 3);
    chk("illegal no mem access", acc_we.size() - ab, 2);
    chk("illegal R1 intact", qget(acc_data, ab), 7);
    chk("R0 stays zero", qget(acc_data, ab+1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
